// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C target controller:
//               protocol state enumeration, ACK/NACK bus levels, byte width
//               and the address-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W = 8;

    // Bus level a receiver puts on SDA in the acknowledge slot
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } i2c_state_t;

    // Address byte is {addr[6:0], rw}; only the upper seven bits select the target
    function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                        input logic [6:0]            dev);
        return addr_byte[I2C_BYTE_W-1:1] == dev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : Two-flop synchronizers for the raw SCL/SDA pad inputs plus a
//               third flop stage for edge detection. Produces SCL edges and
//               START/STOP conditions in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic r_scl_meta;
    logic r_sda_meta;
    logic r_scl_prev;
    logic r_sda_prev;

    // Synchronizer chain; resets to the idle (released, high) bus level so no
    // false edge is seen when reset is removed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_sda_meta <= 1'b1;
            scl_s      <= 1'b1;
            sda_s      <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_i;
            r_sda_meta <= sda_i;
            scl_s      <= r_scl_meta;
            sda_s      <= r_sda_meta;
            r_scl_prev <= scl_s;
            r_sda_prev <= sda_s;
        end
    end

    // Edge and bus-condition decode from the synchronized and delayed copies
    always_comb begin
        scl_rise  =  scl_s & ~r_scl_prev;
        scl_fall  = ~scl_s &  r_scl_prev;
        start_det =  scl_s &  r_sda_prev & ~sda_s;
        stop_det  =  scl_s & ~r_sda_prev &  sda_s;
    end

endmodule
`default_nettype wire

// File: rtl/i2c_target_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_ctrl
// Description : I2C target protocol controller. Matches a 7-bit device
//               address, loads a register pointer on writes, and converts
//               bus transfers into single-cycle register read/write strobes
//               with an auto-incrementing, wrapping pointer. SDA is driven
//               open-drain through sda_oe only.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h2A,
    parameter int unsigned REG_AW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [REG_AW-1:0]     reg_addr,
    output logic [I2C_BYTE_W-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [I2C_BYTE_W-1:0] reg_rdata,
    output logic                  busy
);

    localparam logic [3:0]        c_byte_done = 4'd8;
    localparam logic [REG_AW-1:0] c_ptr_one   = {{(REG_AW-1){1'b0}}, 1'b1};

    logic w_scl_s;
    logic w_sda_s;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_state_t            r_state;
    logic [3:0]            r_bit_cnt;
    logic [I2C_BYTE_W-1:0] r_shift;
    logic                  r_rw;
    logic                  r_mack;
    logic                  r_re_d;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_s     (w_scl_s),
        .sda_s     (w_sda_s),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    // Protocol sequencer: START/STOP override every state; bits are sampled on
    // SCL rise and SDA is only changed after an SCL fall (while SCL is low)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_mack    <= I2C_NACK;
            r_re_d    <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            r_re_d <= reg_re;

            // Pointer advances the cycle after a write strobe used it
            if (reg_we) begin
                reg_addr <= reg_addr + c_ptr_one;
            end

            // Bank data arrives the cycle after the read strobe. For every byte
            // after the first, the MSB goes out as soon as it is available, but
            // only while SCL is still low so SDA never moves during SCL high.
            if (r_re_d) begin
                r_shift <= reg_rdata;
                if (r_state == ST_RDATA && !w_scl_s) begin
                    sda_oe <= ~reg_rdata[I2C_BYTE_W-1];
                end
            end

            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_re_d    <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 4'd0;
                r_re_d    <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (w_scl_rise && r_bit_cnt != c_byte_done) begin
                            r_shift   <= {r_shift[I2C_BYTE_W-2:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == c_byte_done) begin
                            r_bit_cnt <= 4'd0;
                            if (r_state == ST_ADDR) begin
                                if (addr_match(r_shift, DEV_ADDR)) begin
                                    // ACK, and for reads fetch the first byte now
                                    sda_oe  <= 1'b1;
                                    busy    <= 1'b1;
                                    r_rw    <= r_shift[0];
                                    reg_re  <= r_shift[0];
                                    r_state <= ST_ADDR_ACK;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end else if (r_state == ST_PTR) begin
                                reg_addr <= r_shift[REG_AW-1:0];
                                sda_oe   <= 1'b1;
                                r_state  <= ST_PTR_ACK;
                            end else begin
                                reg_we    <= 1'b1;
                                reg_wdata <= r_shift;
                                sda_oe    <= 1'b1;
                                r_state   <= ST_WDATA_ACK;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            if (r_rw) begin
                                sda_oe  <= ~r_shift[I2C_BYTE_W-1];
                                r_state <= ST_RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= ST_PTR;
                            end
                        end
                    end

                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe    <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_WDATA;
                        end
                    end

                    ST_RDATA: begin
                        if (w_scl_rise && r_bit_cnt != c_byte_done) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == c_byte_done) begin
                                sda_oe  <= 1'b0;
                                r_state <= ST_RDATA_ACK;
                            end else if (r_bit_cnt != 4'd0) begin
                                r_shift <= {r_shift[I2C_BYTE_W-2:0], 1'b0};
                                sda_oe  <= ~r_shift[I2C_BYTE_W-2];
                            end
                        end
                    end

                    ST_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= w_sda_s;
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            if (r_mack == I2C_ACK) begin
                                reg_addr <= reg_addr + c_ptr_one;
                                reg_re   <= 1'b1;
                                r_state  <= ST_RDATA;
                            end else begin
                                busy    <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end

                    default: begin
                        sda_oe  <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_target_ctrl
// Description : Self-checking bench: a bit-level I2C master, a register bank
//               behind the target, and a transaction-level reference model
//               (expected register contents and pointer).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_ctrl;

    localparam int         Q    = 6;      // SCL-low half steps (clk cycles)
    localparam int         H    = 10;     // SCL-high time (clk cycles)
    localparam logic [6:0] DEV  = 7'h2A;
    localparam int         AW   = 4;
    localparam int         NREG = 16;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          tb_init = 1'b1;
    logic          scl_m   = 1'b1;
    logic          sda_m   = 1'b1;
    logic          sda_line;
    logic          sda_oe;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [7:0]    reg_rdata;
    logic          busy;

    // Open-drain bus: either side may pull low
    assign sda_line = sda_m & ~sda_oe;

    i2c_target_ctrl #(.DEV_ADDR(DEV), .REG_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register bank the controller sequences; read data one cycle after reg_re
    logic [7:0] bank [NREG];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < NREG; i++) bank[i] <= 8'h00;
            reg_rdata <= 8'h00;
        end else begin
            if (reg_we) bank[reg_addr] <= reg_wdata;
            if (reg_re) reg_rdata <= bank[reg_addr];
        end
    end

    // Strobe / activity monitor
    logic [AW-1:0] we_a [$];
    logic [7:0]    we_d [$];
    int            n_re   = 0;
    int            n_oe   = 0;
    int            n_busy = 0;
    always @(negedge clk) begin
        if (reg_we) begin
            we_a.push_back(reg_addr);
            we_d.push_back(reg_wdata);
        end
        if (reg_re) n_re++;
        if (sda_oe) n_oe++;
        if (busy)   n_busy++;
    end

    // Reference model state
    logic [7:0] exp_bank [NREG];
    int         m_ptr;
    logic [7:0] wbuf [4];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START or repeated START (works from idle or with SCL low)
    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
        tick(Q);
    endtask

    // One SCL clock: master drives b (1 = release), samples the line mid-high
    task automatic i2c_bit(input logic b, output logic s);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(H / 2);
        s = sda_line; tick(H / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic read_byte(input logic last, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(last, s);   // last byte answered with NACK (released)
    endtask

    task automatic op_write(input logic [7:0] pb, input int n);
        int   base, re0, b0, p0;
        logic a;
        base = we_a.size(); re0 = n_re; b0 = n_busy;
        p0   = int'(pb) % NREG;
        i2c_start();
        write_byte({DEV, 1'b0}, a); chk("wr_addr_ack", a, 1);
        write_byte(pb, a);          chk("wr_ptr_ack", a, 1);
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a); chk("wr_data_ack", a, 1);
        end
        chk("wr_busy_during", (n_busy > b0), 1);
        i2c_stop();
        chk("wr_strobe_count", we_a.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < we_a.size()) begin
                chk("wr_strobe_addr", we_a[base + i], (p0 + i) % NREG);
                chk("wr_strobe_data", we_d[base + i], wbuf[i]);
            end
            exp_bank[(p0 + i) % NREG] = wbuf[i];
        end
        m_ptr = (p0 + n) % NREG;
        chk("wr_ptr_end", reg_addr, m_ptr);
        chk("wr_no_read", n_re - re0, 0);
        chk("wr_busy_after", busy, 0);
    endtask

    task automatic op_read(input logic set_ptr, input logic [7:0] pb, input int n);
        int         base, re0, p;
        logic       a;
        logic [7:0] d;
        base = we_a.size(); re0 = n_re;
        p    = set_ptr ? int'(pb) % NREG : m_ptr;
        i2c_start();
        if (set_ptr) begin
            write_byte({DEV, 1'b0}, a); chk("rd_waddr_ack", a, 1);
            write_byte(pb, a);          chk("rd_ptr_ack", a, 1);
            i2c_start();
        end
        write_byte({DEV, 1'b1}, a); chk("rd_addr_ack", a, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            chk("rd_data", d, exp_bank[(p + i) % NREG]);
        end
        chk("rd_busy_after_nack", busy, 0);
        i2c_stop();
        m_ptr = (p + n - 1) % NREG;
        chk("rd_strobe_count", n_re - re0, n);
        chk("rd_ptr_end", reg_addr, m_ptr);
        chk("rd_no_write", we_a.size() - base, 0);
    endtask

    task automatic op_badaddr(input logic [6:0] a7, input logic rw);
        int   base, re0, oe0, b0;
        logic a;
        base = we_a.size(); re0 = n_re; oe0 = n_oe; b0 = n_busy;
        i2c_start();
        write_byte({a7, rw}, a); chk("bad_nack", a, 0);
        i2c_stop();
        chk("bad_sda_never_driven", n_oe - oe0, 0);
        chk("bad_busy_never", n_busy - b0, 0);
        chk("bad_no_strobes", (we_a.size() - base) + (n_re - re0), 0);
        chk("bad_ptr_kept", reg_addr, m_ptr);
    endtask

    task automatic op_abort(input logic [7:0] pb, input int k);
        int   base;
        logic a, s;
        base = we_a.size();
        i2c_start();
        write_byte({DEV, 1'b0}, a); chk("abort_addr_ack", a, 1);
        write_byte(pb, a);          chk("abort_ptr_ack", a, 1);
        for (int i = 0; i < k; i++) i2c_bit(1'($urandom_range(0, 1)), s);
        i2c_stop();
        m_ptr = int'(pb) % NREG;
        chk("abort_no_write", we_a.size() - base, 0);
        chk("abort_sda_released", sda_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ptr", reg_addr, m_ptr);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sda_oe"}, sda_oe, 0);
        chk({tag, "_reg_addr"}, reg_addr, 0);
        chk({tag, "_reg_wdata"}, reg_wdata, 0);
        chk({tag, "_reg_we"}, reg_we, 0);
        chk({tag, "_reg_re"}, reg_re, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         kind, n, k;
        logic [6:0] a7;
        logic       s;

        for (int i = 0; i < NREG; i++) exp_bank[i] = 8'h00;
        m_ptr = 0;

        tick(5);
        check_reset_values("reset");
        rst = 1'b0; tb_init = 1'b0;
        tick(5);

        // Write ptr 3, data A5/5A
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        op_write(8'h03, 2);
        // Set ptr 3, repeated START, read two bytes back
        op_read(1'b1, 8'h03, 2);
        // Address 0x56 byte (target 0x2B) is ignored
        op_badaddr(7'h2B, 1'b0);
        // Pointer wrap 15 -> 0 -> 1
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        op_write(8'h0F, 3);
        // STOP after four data bits, then a normal transaction
        op_abort(8'h07, 4);
        op_read(1'b0, 8'h00, 2);

        // Reset while the address ACK is being driven
        wbuf[0] = 8'hC3;
        op_write(8'h09, 1);
        i2c_start();
        for (int i = 6; i >= 0; i--) i2c_bit(DEV[i], s);
        i2c_bit(1'b0, s);
        chk("rst_ack_driven_before", sda_oe, 1);
        rst = 1'b1;
        tick(1);
        check_reset_values("rst_mid");
        rst   = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(2 * Q);
        m_ptr = 0;

        // Randomized transactions against the model
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                    op_write(8'($urandom), n);
                end
                1: op_read(1'b1, 8'($urandom), $urandom_range(1, 3));
                2: op_read(1'b0, 8'h00, $urandom_range(1, 2));
                3: begin
                    do a7 = 7'($urandom_range(0, 127)); while (a7 == DEV);
                    op_badaddr(a7, 1'($urandom_range(0, 1)));
                end
                default: begin
                    k = $urandom_range(1, 7);
                    op_abort(8'($urandom), k);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
